// File: rtl/dmem_bus_if.sv
// Load/store handshake bundle between the CPU memory stage (master) and dmem_bus (slave).
interface dmem_bus_if #(
  parameter int n = 16
);
  logic         req;
  logic         write_enable;
  logic [1:0]   size;
  logic [n-1:0] addr;
  logic [n-1:0] writedata;
  logic [n-1:0] readdata;
  logic         ready;
  logic         err;

  modport master (
    output req, write_enable, size, addr, writedata,
    input  readdata, ready, err
  );

  modport slave (
    input  req, write_enable, size, addr, writedata,
    output readdata, ready, err
  );
endinterface

// File: rtl/dmem_bus.sv
// Byte-addressed data memory with req/ready handshake, programmable wait states and sub-word access.
// Optional DMEM_BOUNDS_EN: upper address bits beyond the array fault instead of aliasing.
module dmem_bus #(
  parameter int n    = 16,
  parameter int r    = 6,
  parameter int WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_bus_if.slave  bus
);
  localparam int B     = $clog2(n / 8);
  localparam int NL    = n / 8;
  localparam int AW    = B + r;
  localparam int DEPTH = 2 ** r;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state_r;
  logic [3:0]   cnt_r;
  logic         we_r;
  logic [1:0]   size_r;
  logic [n-1:0] addr_r;
  logic [n-1:0] wdata_r;
  logic         ready_r;
  logic         err_r;
  logic [n-1:0] rdata_r;
  logic [n-1:0] mem_r [DEPTH];

  logic         cur_we_s;
  logic [1:0]   cur_size_s;
  logic [n-1:0] cur_addr_s;
  logic [n-1:0] cur_wdata_s;
  logic [B-1:0] lane_s;
  logic [r-1:0] idx_s;
  logic [B+2:0] shamt_s;
  logic         bounds_fault_s;
  logic         fault_s;
  logic         go_resp_s;
  logic         commit_s;
  logic [NL-1:0] be_s;
  logic [n-1:0] wdata_sh_s;
  logic [n-1:0] load_s;

  // Size/alignment fault; reserved size always faults
  function automatic logic fault_of(input logic [1:0] sz, input logic [B-1:0] lane);
    case (sz)
      SZ_BYTE: fault_of = 1'b0;
      SZ_HALF: fault_of = lane[0];
      SZ_WORD: fault_of = |lane;
      default: fault_of = 1'b1;
    endcase
  endfunction

  function automatic logic [NL-1:0] lane_enables(input logic [1:0] sz, input logic [B-1:0] lane);
    case (sz)
      SZ_BYTE: lane_enables = NL'(1) << lane;
      SZ_HALF: lane_enables = NL'(3) << lane;
      default: lane_enables = {NL{1'b1}};
    endcase
  endfunction

  function automatic logic [n-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = n'(8'hFF);
      SZ_HALF: size_mask = n'(16'hFFFF);
      default: size_mask = {n{1'b1}};
    endcase
  endfunction

  // With zero wait states the response edge is the request edge, so decode from the live inputs
  always_comb begin
    cur_we_s    = we_r;
    cur_size_s  = size_r;
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    if (state_r == S_IDLE) begin
      cur_we_s    = bus.write_enable;
      cur_size_s  = bus.size;
      cur_addr_s  = bus.addr;
      cur_wdata_s = bus.writedata;
    end else begin
      cur_we_s    = we_r;
      cur_size_s  = size_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign lane_s  = cur_addr_s[B-1:0];
  assign idx_s   = cur_addr_s[AW-1:B];
  assign shamt_s = {lane_s, 3'b000};

`ifdef DMEM_BOUNDS_EN
  assign bounds_fault_s = |(cur_addr_s >> AW);
`else
  logic [n-1:0] addr_hi_unused_s;
  assign addr_hi_unused_s = cur_addr_s >> AW;
  assign bounds_fault_s   = 1'b0;
`endif

  assign fault_s    = fault_of(cur_size_s, lane_s) | bounds_fault_s;
  assign go_resp_s  = ((state_r == S_IDLE) & bus.req & (WAIT == 0)) |
                      ((state_r == S_WAIT) & (cnt_r == 4'd0));
  assign commit_s   = go_resp_s & cur_we_s & ~fault_s & ~rst;
  assign be_s       = lane_enables(cur_size_s, lane_s);
  assign wdata_sh_s = cur_wdata_s << shamt_s;
  assign load_s     = (mem_r[idx_s] >> shamt_s) & size_mask(cur_size_s);

  // Handshake FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= '0;
      wdata_r <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      if (go_resp_s) begin
        ready_r <= 1'b1;
        err_r   <= fault_s;
        if (fault_s) begin
          rdata_r <= '0;
        end else if (!cur_we_s) begin
          rdata_r <= load_s;
        end
      end
      case (state_r)
        S_IDLE: begin
          if (bus.req) begin
            we_r    <= bus.write_enable;
            size_r  <= bus.size;
            addr_r  <= bus.addr;
            wdata_r <= bus.writedata;
            cnt_r   <= WAIT_LOAD;
            state_r <= (WAIT > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Byte-lane store commit; storage itself is never cleared by reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (commit_s && be_s[i]) begin
        mem_r[idx_s][i*8 +: 8] <= wdata_sh_s[i*8 +: 8];
      end
    end
  end

  assign bus.ready    = ready_r;
  assign bus.err      = err_r;
  assign bus.readdata = rdata_r;
endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus: n=16, r=6 with WAIT=1 (main) and WAIT=3 (issue-rate) instances.
module tb_dmem_bus;
  logic clk;
  logic rst1;
  logic rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [1:0] BY = 2'b00;
  localparam logic [1:0] HW = 2'b01;
  localparam logic [1:0] WD = 2'b10;
  localparam logic [1:0] RS = 2'b11;

  dmem_bus_if #(.n(16)) bus1 ();
  dmem_bus_if #(.n(16)) bus3 ();

  dmem_bus #(.n(16), .r(6), .WAIT(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  dmem_bus #(.n(16), .r(6), .WAIT(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT=1 instance; lat is the cycle index (1 = cycle after sampling edge) where ready is seen
  task automatic xfer(input logic we, input logic [1:0] sz, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic e, output int lat, output logic after);
    @(negedge clk);
    bus1.req = 1'b1; bus1.write_enable = we; bus1.size = sz; bus1.addr = a; bus1.writedata = wd;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    lat = 1;
    while (!bus1.ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus1.readdata;
    e  = bus1.err;
    @(posedge clk); #1;
    after = bus1.ready;
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_err);
    logic [15:0] rd;
    logic        e;
    logic        after;
    int          lat;
    xfer(we, sz, a, wd, rd, e, lat, after);
    chk({tag, " lat"}, 16'(lat), 16'd2);
    chk({tag, " err"}, {15'd0, e}, {15'd0, exp_err});
    if (!we || exp_err) chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " pulse"}, {15'd0, after}, 16'd0);
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.req = 1'b0; bus1.write_enable = 1'b0; bus1.size = 2'b00; bus1.addr = 16'h0000; bus1.writedata = 16'h0000;
    bus3.req = 1'b0; bus3.write_enable = 1'b0; bus3.size = WD;    bus3.addr = 16'h0000; bus3.writedata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    chk("reset ready", {15'd0, bus1.ready}, 16'd0);
    chk("reset err", {15'd0, bus1.err}, 16'd0);
    chk("reset rdata", bus1.readdata, 16'h0000);

    run("st w 4", 1'b1, WD, 16'h0004, 16'hBEEF, 16'h0000, 1'b0);
    run("ld w 4", 1'b0, WD, 16'h0004, 16'h0000, 16'hBEEF, 1'b0);
    run("st b 5", 1'b1, BY, 16'h0005, 16'h0012, 16'h0000, 1'b0);
    run("ld w 4 merged", 1'b0, WD, 16'h0004, 16'h0000, 16'h12EF, 1'b0);
    run("ld b 5", 1'b0, BY, 16'h0005, 16'h0000, 16'h0012, 1'b0);
    run("ld b 4", 1'b0, BY, 16'h0004, 16'h0000, 16'h00EF, 1'b0);
    chk("rdata hold", bus1.readdata, 16'h00EF);

    run("st w 2", 1'b1, WD, 16'h0002, 16'h1234, 16'h0000, 1'b0);
    run("ld w 3 misaligned", 1'b0, WD, 16'h0003, 16'h0000, 16'h0000, 1'b1);
    run("st w 3 misaligned", 1'b1, WD, 16'h0003, 16'hFFFF, 16'h0000, 1'b1);
    run("ld w 2 unchanged", 1'b0, WD, 16'h0002, 16'h0000, 16'h1234, 1'b0);
    run("ld b 3", 1'b0, BY, 16'h0003, 16'h0000, 16'h0012, 1'b0);

    run("ld rsvd", 1'b0, RS, 16'h0004, 16'h0000, 16'h0000, 1'b1);
    run("st rsvd", 1'b1, RS, 16'h0004, 16'h5555, 16'h0000, 1'b1);
    run("ld w 4 after rsvd", 1'b0, WD, 16'h0004, 16'h0000, 16'h12EF, 1'b0);
    run("ld h 4", 1'b0, HW, 16'h0004, 16'h0000, 16'h12EF, 1'b0);
    run("ld h 5 misaligned", 1'b0, HW, 16'h0005, 16'h0000, 16'h0000, 1'b1);
    run("st h 6", 1'b1, HW, 16'h0006, 16'hABCD, 16'h0000, 1'b0);
    run("ld b 7", 1'b0, BY, 16'h0007, 16'h0000, 16'h00AB, 1'b0);

    // Reset during WAIT aborts the store and suppresses its response
    run("st w 8", 1'b1, WD, 16'h0008, 16'h2222, 16'h0000, 1'b0);
    @(negedge clk);
    bus1.req = 1'b1; bus1.write_enable = 1'b1; bus1.size = WD; bus1.addr = 16'h0008; bus1.writedata = 16'h1111;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort no ready", {15'd0, bus1.ready}, 16'd0);
      @(posedge clk); #1;
    end
    run("ld w 8 after abort", 1'b0, WD, 16'h0008, 16'h0000, 16'h2222, 1'b0);

    // rst and req together: reset wins, no response follows
    @(negedge clk);
    bus1.req = 1'b1; bus1.write_enable = 1'b0; bus1.size = WD; bus1.addr = 16'h0008;
    rst1 = 1'b1;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst over req", {15'd0, bus1.ready}, 16'd0);
      @(posedge clk); #1;
    end

    run("st w 0", 1'b1, WD, 16'h0000, 16'hA5A5, 16'h0000, 1'b0);
`ifdef DMEM_BOUNDS_EN
    run("ld w 80 bounds", 1'b0, WD, 16'h0080, 16'h0000, 16'h0000, 1'b1);
`else
    run("ld w 80 alias", 1'b0, WD, 16'h0080, 16'h0000, 16'hA5A5, 1'b0);
`endif

    // Continuous req on WAIT=3: ready at edges 3, 8, 13, ... after the first sampling edge
    @(negedge clk);
    bus3.req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w3 pulse %0d", i), {15'd0, bus3.ready}, {15'd0, (i % 5) == 3});
    end
    bus3.req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
